// File: rtl/chip8_pkg.sv
// Shared CHIP-8 definitions: screen geometry, sprite limits and the draw
// sequencer state encoding, plus a helper for the optional vertical clip.
package chip8_pkg;

  localparam int SCREEN_W        = 64;
  localparam int SCREEN_H        = 32;
  localparam int MAX_SPRITE_ROWS = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DRAW   = 3'd3,
    COLL   = 3'd4,
    FINISH = 3'd5
  } draw_state_t;

  // True when sprite row 'row' drawn from base line 'y' falls below the screen.
  function automatic logic row_clipped(input logic [4:0] y, input logic [3:0] row);
    logic [5:0] line;
    line = {1'b0, y} + {2'b00, row};
    return line >= 6'(SCREEN_H);
  endfunction

endpackage

// File: rtl/chip8_draw_ctrl_if.sv
// Bundle of the CPU request, memory read port, display draw port and VF
// result signals of the DXYN draw sequencer.
// master: the sequencer itself.  slave: the CPU / memory / display side.
interface chip8_draw_ctrl_if #(
  parameter int ADDR_W = 12
);

  // CPU request
  logic              start;
  logic [7:0]        vx;
  logic [7:0]        vy;
  logic [3:0]        n;
  logic [ADDR_W-1:0] i_addr;

  // Memory read port
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data_in;

  // Display draw port
  logic              draw;
  logic [5:0]        draw_x;
  logic [4:0]        draw_y;
  logic [3:0]        draw_row_index;
  logic [7:0]        sprite_data;
  logic              collision;

  // Status and VF result
  logic              busy;
  logic              done;
  logic              vf_we;
  logic [7:0]        vf_out;

  modport master (
    input  start, vx, vy, n, i_addr, mem_data_in, collision,
    output mem_read, mem_addr, draw, draw_x, draw_y, draw_row_index,
           sprite_data, busy, done, vf_we, vf_out
  );

  modport slave (
    output start, vx, vy, n, i_addr, mem_data_in, collision,
    input  mem_read, mem_addr, draw, draw_x, draw_y, draw_row_index,
           sprite_data, busy, done, vf_we, vf_out
  );

endinterface

// File: rtl/chip8_draw_ctrl.sv
// CHIP-8 DXYN sprite-draw sequencer.
// For each of the n sprite rows it fetches one byte at I+row, hands it to the
// display together with the latched coordinates and row index, and ORs the
// returned collision flags into the VF result. Four cycles per row.
// Build option: CHIP8_DRAW_CLIP_EN -- when defined, the sequence ends at the
// first row that would fall below the bottom edge of the screen instead of
// leaving vertical wrap to the display.
module chip8_draw_ctrl
  import chip8_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  chip8_draw_ctrl_if.master     bus
);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_FETCH  = 3'(FETCH);
  localparam logic [2:0] ST_WAIT   = 3'(WAIT);
  localparam logic [2:0] ST_DRAW   = 3'(DRAW);
  localparam logic [2:0] ST_COLL   = 3'(COLL);
  localparam logic [2:0] ST_FINISH = 3'(FINISH);

  logic [2:0]        state;
  logic [2:0]        state_d;

  logic [5:0]        x_q;
  logic [4:0]        y_q;
  logic [3:0]        n_q;
  logic [ADDR_W-1:0] base_q;
  logic [3:0]        row_q;
  logic [7:0]        sprite_q;
  logic              acc_q;

  logic              last_row;
  logic [ADDR_W-1:0] row_addr;

  // Only the low coordinate bits matter; the upper VX/VY bits are dropped.
  logic              unused_coord_bits;
  assign unused_coord_bits = &{1'b0, bus.vx[7:6], bus.vy[7:5]};

  assign row_addr = base_q + {{(ADDR_W-4){1'b0}}, row_q};

`ifdef CHIP8_DRAW_CLIP_EN
  assign last_row = (row_q == (n_q - 4'd1)) || row_clipped(y_q, row_q + 4'd1);
`else
  assign last_row = (row_q == (n_q - 4'd1));
`endif

  // Next-state decode: one row is FETCH, WAIT, DRAW, COLL; FINISH closes out.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.n == 4'd0) ? ST_FINISH : ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_DRAW;
      ST_DRAW:   state_d = ST_COLL;
      ST_COLL:   state_d = last_row ? ST_FINISH : ST_FETCH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register; a start while busy is simply never looked at.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Request latch, row counter, sprite byte and collision accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q      <= '0;
      y_q      <= '0;
      n_q      <= '0;
      base_q   <= '0;
      row_q    <= '0;
      sprite_q <= '0;
      acc_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            x_q    <= bus.vx[5:0];
            y_q    <= bus.vy[4:0];
            n_q    <= bus.n;
            base_q <= bus.i_addr;
            row_q  <= '0;
            acc_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          sprite_q <= bus.mem_data_in;
        end
        ST_COLL: begin
          acc_q <= acc_q | bus.collision;
          if (!last_row) begin
            row_q <= row_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_read       = (state == ST_FETCH);
  assign bus.mem_addr       = (state == ST_FETCH) ? row_addr : '0;
  assign bus.draw           = (state == ST_DRAW);
  assign bus.draw_x         = x_q;
  assign bus.draw_y         = y_q;
  assign bus.draw_row_index = row_q;
  assign bus.sprite_data    = sprite_q;
  assign bus.busy           = (state != ST_IDLE);
  assign bus.done           = (state == ST_FINISH);
  assign bus.vf_we          = (state == ST_FINISH);
  assign bus.vf_out         = {7'b0000000, acc_q};

endmodule

// File: tb/tb_chip8_draw_ctrl.sv
// Self-checking bench for chip8_draw_ctrl: directed DXYN draws followed by
// randomized ones, each compared cycle by cycle against a row-count model.
module tb_chip8_draw_ctrl;
  import chip8_pkg::*;

  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic reset;

  chip8_draw_ctrl_if #(.ADDR_W(ADDR_W)) bus();

  chip8_draw_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:4095];
  logic [15:0] coll_mask;

  int total = 0;
  int bad   = 0;

  // Memory answers one cycle after the read; display reports collision one cycle after draw.
  always @(posedge clk) begin
    bus.mem_data_in <= bus.mem_read ? mem[bus.mem_addr] : 8'h00;
    bus.collision   <= bus.draw ? coll_mask[bus.draw_row_index] : 1'b0;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, ".busy"},        32'(bus.busy),           32'd0);
    check_output({tag, ".mem_read"},    32'(bus.mem_read),       32'd0);
    check_output({tag, ".mem_addr"},    32'(bus.mem_addr),       32'd0);
    check_output({tag, ".draw"},        32'(bus.draw),           32'd0);
    check_output({tag, ".draw_x"},      32'(bus.draw_x),         32'd0);
    check_output({tag, ".draw_y"},      32'(bus.draw_y),         32'd0);
    check_output({tag, ".row_index"},   32'(bus.draw_row_index), 32'd0);
    check_output({tag, ".sprite_data"}, 32'(bus.sprite_data),    32'd0);
    check_output({tag, ".done"},        32'(bus.done),           32'd0);
    check_output({tag, ".vf_we"},       32'(bus.vf_we),          32'd0);
    check_output({tag, ".vf_out"},      32'(bus.vf_out),         32'd0);
  endtask

  // Number of rows the sequencer should actually draw for this request.
  function automatic int expected_rows(input logic [7:0] vy, input logic [3:0] n);
    int rows = int'(n);
`ifdef CHIP8_DRAW_CLIP_EN
    int ybase = int'(vy) % SCREEN_H;
    if (ybase + rows > SCREEN_H) rows = SCREEN_H - ybase;
`endif
    return rows;
  endfunction

  // One complete draw starting at the current negedge (this is cycle 0).
  // intrude_cyc selects a cycle in which a stray start with junk operands is driven.
  task automatic apply_stimulus(input logic [7:0] vx, input logic [7:0] vy, input logic [3:0] n,
                                input logic [11:0] i_base, input logic [15:0] mask,
                                input int intrude_cyc);
    int   rows;
    int   done_cyc;
    int   r;
    int   ph;
    bit   in_rows;
    logic exp_vf;
    logic [11:0] addr;

    rows     = expected_rows(vy, n);
    done_cyc = (rows == 0) ? 1 : 4 * rows + 1;
    exp_vf   = 1'b0;
    for (int k = 0; k < rows; k++) exp_vf |= mask[k];
    coll_mask = mask;

    bus.start  = 1'b1;
    bus.vx     = vx;
    bus.vy     = vy;
    bus.n      = n;
    bus.i_addr = i_base;
    @(negedge clk);

    for (int cyc = 1; cyc <= done_cyc; cyc++) begin
      if (cyc == intrude_cyc) begin
        bus.start  = 1'b1;
        bus.vx     = 8'($urandom);
        bus.vy     = 8'($urandom);
        bus.n      = 4'($urandom);
        bus.i_addr = 12'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      r       = (cyc - 1) / 4;
      ph      = (cyc - 1) % 4;
      in_rows = (cyc < done_cyc);
      addr    = i_base + 12'(r);

      check_output("busy",     32'(bus.busy),     32'd1);
      check_output("done",     32'(bus.done),     32'(cyc == done_cyc));
      check_output("vf_we",    32'(bus.vf_we),    32'(cyc == done_cyc));
      check_output("mem_read", 32'(bus.mem_read), 32'(in_rows && ph == 0));
      check_output("draw",     32'(bus.draw),     32'(in_rows && ph == 2));
      if (in_rows && ph == 0) begin
        check_output("mem_addr", 32'(bus.mem_addr), 32'(addr));
      end
      if (in_rows && (ph == 2 || ph == 3)) begin
        check_output("draw_x",      32'(bus.draw_x),         32'(vx % 8'd64));
        check_output("draw_y",      32'(bus.draw_y),         32'(vy % 8'd32));
        check_output("row_index",   32'(bus.draw_row_index), 32'(r));
        check_output("sprite_data", 32'(bus.sprite_data),    32'(mem[addr]));
      end
      if (cyc == done_cyc) begin
        check_output("vf_out", 32'(bus.vf_out), 32'({7'd0, exp_vf}));
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    check_output("idle_after_done", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.vx         = '0;
    bus.vy         = '0;
    bus.n          = '0;
    bus.i_addr     = '0;
    coll_mask      = '0;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[12'h050] = 8'hF0;
    mem[12'h051] = 8'h90;
    mem[12'h052] = 8'h90;
    mem[12'h053] = 8'h90;
    mem[12'h054] = 8'hF0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    $display("[TB] reset checks complete");

    // Font-style sprite, no collisions, then the same with a hit on row 2 back-to-back.
    apply_stimulus(8'd10, 8'd3, 4'd5, 12'h050, 16'h0000, 0);
    apply_stimulus(8'd10, 8'd3, 4'd5, 12'h050, 16'h0004, 7);
    // Zero-height sprite.
    apply_stimulus(8'd10, 8'd3, 4'd0, 12'h050, 16'hFFFF, 0);
    // Address wrap and coordinate masking.
    apply_stimulus(8'd70, 8'd40, 4'd3, 12'hFFE, 16'h0002, 0);
    // Bottom-edge case (clipped in the clip build, full in the default build).
    apply_stimulus(8'd5, 8'd30, 4'd4, 12'h200, 16'h0008, 0);
    $display("[TB] directed draws complete");

    // Reset in cycle 6 of an n=4 draw, with a stray start in cycle 2.
    coll_mask  = 16'hFFFF;
    bus.start  = 1'b1;
    bus.vx     = 8'd12;
    bus.vy     = 8'd7;
    bus.n      = 4'd4;
    bus.i_addr = 12'h300;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.n     = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_output("post_reset.busy",     32'(bus.busy),     32'd0);
      check_output("post_reset.draw",     32'(bus.draw),     32'd0);
      check_output("post_reset.mem_read", 32'(bus.mem_read), 32'd0);
      check_output("post_reset.done",     32'(bus.done),     32'd0);
    end

    // Start coinciding with reset is dropped.
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.n     = 4'd3;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check_output("start_with_reset.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check_output("start_with_reset.mem_read", 32'(bus.mem_read), 32'd0);
    $display("[TB] reset scenarios complete");

    // Randomized draws, sometimes back-to-back, sometimes with idle gaps.
    for (int t = 0; t < 30; t++) begin
      logic [3:0] rn;
      rn = 4'($urandom);
      apply_stimulus(8'($urandom), 8'($urandom), rn, 12'($urandom), 16'($urandom),
                     int'($urandom_range(0, 4 * int'(rn) + 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("[TB] random draws complete");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip8_draw_ctrl.md
# chip8_draw_ctrl

Sequencer for the CHIP-8 DXYN sprite-draw operation. On a start pulse from `chip8_cpu`, it fetches N sprite bytes from `chip8_mem` starting at I, one per row. It presents each byte to `chip8_display` with the draw coordinates and row index, and ORs the per-row collision flags into a VF result. The CPU stays stalled on `busy` while this block owns the memory read port and the display draw port.

## Interface
Parameters:
- `ADDR_W`, 12: memory address width; I+row wraps modulo 2^ADDR_W.

Ports:
- `clk`  in  1  system clock. Single clock domain; reset is synchronous and active-high.
- `reset`  in  1  synchronous active-high reset.
- `start`  in  1  one-cycle request to draw a sprite; ignored unless the block is idle.
- `vx`  in  8  X coordinate (VX); only bits [5:0] are used (mod 64).
- `vy`  in  8  Y coordinate (VY); only bits [4:0] are used (mod 32).
- `n`  in  4  sprite height in rows, 0..15.
- `i_addr`  in  ADDR_W  sprite base address (I).
- `mem_read`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_data_in`  in  8  memory read data, valid one cycle after `mem_read`.
- `draw`  out  1  one-cycle display draw strobe.
- `draw_x`  out  6  latched X coordinate.
- `draw_y`  out  5  latched Y base coordinate.
- `draw_row_index`  out  4  current row, 0..n-1.
- `sprite_data`  out  8  sprite byte for the current row.
- `collision`  in  1  display collision flag, valid one cycle after `draw`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `vf_we`  out  1  VF write enable; asserted together with `done`.
- `vf_out`  out  8  VF value: 8'h01 if any row collided, else 8'h00.

## Operation
- State machine: IDLE → FETCH → WAIT → DRAW → COLL → (FETCH for the next row | FINISH) → IDLE.
- IDLE: when `start` is high, latch `vx[5:0]`, `vy[4:0]`, `n` and `i_addr`; clear the row counter and the collision accumulator.
  - If n==0, go to FINISH; otherwise go to FETCH.
- FETCH: assert `mem_read`, with `mem_addr` = (I + row) mod 2^ADDR_W.
- WAIT: capture `mem_data_in` into the sprite register.
- DRAW: assert `draw` for one cycle. `sprite_data`, `draw_x`, `draw_y` and `draw_row_index` hold their values through DRAW and COLL.
- COLL: accumulate collision as acc |= `collision`. Then increment row.
  - If row == n-1, go to FINISH; otherwise go to FETCH.
- FINISH: assert `done` and `vf_we` for one cycle; `vf_out` = {7'b0, acc}; return to IDLE.
- Y wrap of rows past the bottom edge is performed by the display, which receives `draw_y` plus `draw_row_index`; this block does not add them.
- A `start` pulse while busy is dropped with no side effects.

## Timing
- Take the cycle in which `start` is sampled in IDLE as cycle 0. For row r (0-based):
  - `mem_read` is high in cycle 4r+1.
  - `draw` is high in cycle 4r+3.
  - `collision` is sampled in cycle 4r+4.
- `done`: high in cycle 4n+1 for n≥1, and in cycle 1 for n==0.
- Back-to-back: a new `start` is accepted in the cycle after `done`.
- Reset values: state IDLE; all outputs 0, including `vf_out`, `sprite_data`, `draw_x`, `draw_y` and `draw_row_index`.
- Reset mid-operation: return to IDLE on the next edge. No `done`, no `vf_we`, and no further `draw` or `mem_read`.
- `start` asserted in the same cycle as `reset`: `reset` wins.

## Configuration
- `CHIP8_DRAW_CLIP_EN` defined: rows with vy[4:0]+row ≥ 32 are clipped.
  - The sequencer terminates at the first such row and goes straight to FINISH.
  - Clipped rows issue no fetch, no draw and no collision sample.
  - `done` timing is 4·(rows drawn)+1.
- `CHIP8_DRAW_CLIP_EN` undefined: all n rows are sequenced and vertical wrap is left to the display, as described above.

## Structure
- Shared `chip8_pkg` holds:
  - `SCREEN_W`=64, `SCREEN_H`=32, `MAX_SPRITE_ROWS`=15.
  - The state enum `draw_state_t` (IDLE, FETCH, WAIT, DRAW, COLL, FINISH).
- No sub-module: a single FSM plus the row counter, address adder and collision accumulator.

## Test plan
- n=5, I=0x050, vx=10, vy=3, memory bytes F0,90,90,90,F0, no collisions:
  - `mem_addr` reads 0x050..0x054 in cycles 1,5,9,13,17.
  - Five `draw` pulses with `draw_row_index` 0..4 and the matching `sprite_data`.
  - `done` in cycle 21; `vf_out`=00.
- Same draw with `collision`=1 only after row 2: `vf_out`=01 and `vf_we`=1 in cycle 21.
- n=0: no `mem_read`, no `draw`; `done` and `vf_we` in cycle 1 with `vf_out`=00.
- I=0xFFE, n=3: `mem_addr` sequence 0xFFE, 0xFFF, 0x000.
  - vx=70, vy=40 → `draw_x`=6, `draw_y`=8.
- `reset` asserted in cycle 6 of an n=4 draw: IDLE next cycle, all outputs 0, no `done`.
  - A second `start` during an active draw is ignored.
- With `CHIP8_DRAW_CLIP_EN` defined, vy=30, n=4: only rows 0 and 1 are drawn; `done` in cycle 9.
